// File: rtl/hamming_counter_decoder.sv
// Purpose : SECDED(16,11) receive-side decoder for the counter bus, with saturating error stats.
// Latency : 2 cycles (valid_in captured at edge N, valid_out asserted by edge N+1 after that capture).
// Backpressure: none; fully pipelined, one word per cycle, every accepted word is emitted.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   valid_in, code_in        incoming code word ([0]=overall parity, [p]=Hamming position p)
//   clr_cnt                  clears corr_cnt/uncorr_cnt (wins over a same-cycle increment)
//   valid_out, data_out      corrected 11-bit counter value
//   err_corr, err_uncorr     single-error-corrected / double-error-detected flags (0 when !valid_out)
//   corr_cnt, uncorr_cnt     saturating error counters
//   locked, seq_err          sequence checker status / 1-cycle break pulse
//
// Build option: define HAMDEC_SEQ_CHECK_EN to build the +1 sequence checker;
// without it locked and seq_err are tied low.

module hamming_counter_decoder #(
    parameter int DW     = 11,
    parameter int CNT_W  = 8,
    parameter int LOCK_N = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [15:0]      code_in,
    input  logic             clr_cnt,
    output logic             valid_out,
    output logic [DW-1:0]    data_out,
    output logic             err_corr,
    output logic             err_uncorr,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt,
    output logic             locked,
    output logic             seq_err
);

    // Syndrome is the XOR of the indices of every set position 1..15;
    // equivalent to the per-bit parity groups but written once.
    logic [3:0] syn;
    logic       par;

    always_comb begin
        syn = '0;
        for (int p = 1; p < 16; p++) begin
            if (code_in[p]) syn = syn ^ 4'(p);
        end
    end

    assign par = ^code_in;

    // ---------------- stage 1 ----------------
    logic        s1_vld;
    logic [15:0] s1_code;
    logic [3:0]  s1_syn;
    logic        s1_par;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_vld  <= 1'b0;
            s1_code <= '0;
            s1_syn  <= '0;
            s1_par  <= 1'b0;
        end else begin
            s1_vld <= valid_in;
            if (valid_in) begin
                s1_code <= code_in;
                s1_syn  <= syn;
                s1_par  <= par;
            end
        end
    end

    // ---------------- decode ----------------
    // Only flip when the overall parity confirms an odd error count; a zero
    // syndrome with bad parity means the error was in code[0] itself.
    logic [15:0]   fixed;
    logic [DW-1:0] dec_data;
    logic          dec_corr;
    logic          dec_uncorr;

    always_comb begin
        fixed = s1_code;
        if (s1_par && (s1_syn != 4'd0)) fixed[s1_syn] = ~fixed[s1_syn];
    end

    assign dec_data   = {fixed[15:9], fixed[7:5], fixed[3]};
    assign dec_corr   = s1_vld & s1_par;
    assign dec_uncorr = s1_vld & ~s1_par & (s1_syn != 4'd0);

    // Parity positions carry no payload once decoded.
    logic unused_pbits;
    assign unused_pbits = ^{fixed[8], fixed[4], fixed[2:0]};

    // ---------------- stage 2 + counters ----------------
    // Counters update on the same edge that presents the word, so they
    // already include it while valid_out is high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_out  <= 1'b0;
            data_out   <= '0;
            err_corr   <= 1'b0;
            err_uncorr <= 1'b0;
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else begin
            valid_out  <= s1_vld;
            err_corr   <= dec_corr;
            err_uncorr <= dec_uncorr;
            if (s1_vld) data_out <= dec_data;

            if (clr_cnt)                             corr_cnt <= '0;
            else if (dec_corr && (corr_cnt != '1))   corr_cnt <= corr_cnt + 1'b1;

            if (clr_cnt)                             uncorr_cnt <= '0;
            else if (dec_uncorr && (uncorr_cnt != '1)) uncorr_cnt <= uncorr_cnt + 1'b1;
        end
    end

`ifdef HAMDEC_SEQ_CHECK_EN
    // ---------------- sequence checker ----------------
    typedef enum logic {UNLOCKED, LOCKED} seq_state_t;

    // match_cnt only needs to reach LOCK_N-1; the LOCK_N-th match locks instead.
    localparam int MW = (LOCK_N < 2) ? 1 : $clog2(LOCK_N);

    seq_state_t    state, state_n;
    logic [MW-1:0] match_cnt, match_n;
    logic [DW-1:0] exp_val, exp_n;
    logic          have_exp, have_n;
    logic          seq_err_n;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= UNLOCKED;
            match_cnt <= '0;
            exp_val   <= '0;
            have_exp  <= 1'b0;
            seq_err   <= 1'b0;
        end else begin
            state     <= state_n;
            match_cnt <= match_n;
            exp_val   <= exp_n;
            have_exp  <= have_n;
            seq_err   <= seq_err_n;
        end
    end

    always_comb begin
        state_n   = state;
        match_n   = match_cnt;
        exp_n     = exp_val;
        have_n    = have_exp;
        seq_err_n = 1'b0;
        if (s1_vld) begin
            case (state)
                UNLOCKED: begin
                    // Uncorrectable words carry no trustworthy value to train on.
                    if (!dec_uncorr) begin
                        have_n = 1'b1;
                        exp_n  = dec_data + 1'b1;
                        if (!have_exp) begin
                            match_n = '0;
                        end else if (dec_data == exp_val) begin
                            if (match_cnt == MW'(LOCK_N - 1)) begin
                                state_n = LOCKED;
                                match_n = '0;
                            end else begin
                                match_n = match_cnt + 1'b1;
                            end
                        end else begin
                            match_n = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (dec_uncorr || (dec_data == exp_val)) begin
                        exp_n = exp_val + 1'b1;
                    end else begin
                        seq_err_n = 1'b1;
                        state_n   = UNLOCKED;
                        match_n   = '0;
                        exp_n     = dec_data + 1'b1;
                    end
                end
                default: state_n = UNLOCKED;
            endcase
        end
    end

    assign locked = (state == LOCKED);
`else
    assign locked  = 1'b0;
    assign seq_err = 1'b0;

    logic unused_lock_n;
    assign unused_lock_n = (LOCK_N > 0);
`endif

endmodule

// File: tb/tb_hamming_counter_decoder.sv
// Purpose : self-checking bench for hamming_counter_decoder against a spec-level reference model.
// Latency : expects outputs 2 edges after a word is driven.
// Backpressure: none; the bench streams one word per cycle when it wants to.

module tb_hamming_counter_decoder;

`ifdef HAMDEC_SEQ_CHECK_EN
    localparam bit SEQ = 1'b1;
`else
    localparam bit SEQ = 1'b0;
`endif
    localparam int LOCK_N = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [15:0] code_in;
    logic        clr_cnt;
    logic        valid_out;
    logic [10:0] data_out;
    logic        err_corr;
    logic        err_uncorr;
    logic [7:0]  corr_cnt;
    logic [7:0]  uncorr_cnt;
    logic        locked;
    logic        seq_err;

    hamming_counter_decoder dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .code_in(code_in), .clr_cnt(clr_cnt),
        .valid_out(valid_out), .data_out(data_out), .err_corr(err_corr), .err_uncorr(err_uncorr),
        .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt), .locked(locked), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          vld;
        logic [10:0] data;
        bit          corr;
        bit          uncorr;
    } item_t;

    int    n_pass = 0;
    int    n_total = 0;

    // reference model state
    item_t q[$];
    item_t cur;
    int    m_corr, m_uncorr;
    bit    m_locked, m_have, m_seq_err;
    int    m_match, m_exp;

    function automatic item_t mk(input bit v, input logic [10:0] d, input bit c, input bit u);
        item_t e;
        e.vld = v; e.data = d; e.corr = c; e.uncorr = u;
        return e;
    endfunction

    // Data goes into every non-power-of-two position in ascending order.
    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] c;
        int i;
        c = '0;
        i = 0;
        for (int p = 1; p < 16; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p] = d[i];
                i++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            logic pb;
            pb = 1'b0;
            for (int p = 1; p < 16; p++) begin
                if (p != (1 << k) && ((p >> k) & 1) == 1) pb ^= c[p];
            end
            c[1 << k] = pb;
        end
        c[0] = ^c[15:1];
        return c;
    endfunction

    function automatic logic [10:0] raw_data(input logic [15:0] c);
        logic [10:0] r;
        int i;
        r = '0;
        i = 0;
        for (int p = 1; p < 16; p++) begin
            if ((p & (p - 1)) != 0) begin
                r[i] = c[p];
                i++;
            end
        end
        return r;
    endfunction

    // One clock: drive, take the edge, then advance the model to what the DUT shows now.
    task automatic step(input bit v, input logic [15:0] code, input bit clr, input bit rv, input item_t e);
        valid_in = v;
        code_in  = code;
        clr_cnt  = clr;
        rst      = rv;
        @(posedge clk);
        #1;
        m_seq_err = 1'b0;
        if (!rv) begin
            q.delete();
            cur = mk(0, 0, 0, 0);
            m_corr = 0; m_uncorr = 0;
            m_locked = 1'b0; m_have = 1'b0; m_match = 0; m_exp = 0;
        end else begin
            e.vld = v;
            q.push_back(e);
            if (q.size() == 2) cur = q.pop_front();
            else cur = mk(0, 0, 0, 0);
            if (clr) begin
                m_corr = 0;
                m_uncorr = 0;
            end else if (cur.vld) begin
                if (cur.corr && m_corr < 255) m_corr++;
                if (cur.uncorr && m_uncorr < 255) m_uncorr++;
            end
            if (cur.vld && SEQ) begin
                if (!m_locked) begin
                    if (!cur.uncorr) begin
                        if (!m_have) m_match = 0;
                        else if (int'(cur.data) == m_exp) m_match++;
                        else m_match = 0;
                        m_have = 1'b1;
                        m_exp = (int'(cur.data) + 1) % 2048;
                        if (m_match == LOCK_N) begin
                            m_locked = 1'b1;
                            m_match = 0;
                        end
                    end
                end else if (cur.uncorr || int'(cur.data) == m_exp) begin
                    m_exp = (m_exp + 1) % 2048;
                end else begin
                    m_seq_err = 1'b1;
                    m_locked = 1'b0;
                    m_match = 0;
                    m_exp = (int'(cur.data) + 1) % 2048;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 16'h0000, 0, 1, mk(0, 0, 0, 0));
    endtask

    task automatic test_reset;
        step(0, 16'h0000, 0, 0, mk(0, 0, 0, 0));
        step(0, 16'h0000, 0, 0, mk(0, 0, 0, 0));
        n_total++; if (valid_out !== 1'b0) $display("FAIL reset_valid_out: got %b want 0", valid_out); else n_pass++;
        n_total++; if (data_out !== 11'd0) $display("FAIL reset_data_out: got %0d want 0", data_out); else n_pass++;
        n_total++; if ({err_corr, err_uncorr} !== 2'b00) $display("FAIL reset_err_flags: got %b want 00", {err_corr, err_uncorr}); else n_pass++;
        n_total++; if ({corr_cnt, uncorr_cnt} !== 16'h0000) $display("FAIL reset_counters: got %h want 0000", {corr_cnt, uncorr_cnt}); else n_pass++;
        n_total++; if ({locked, seq_err} !== 2'b00) $display("FAIL reset_seq: got %b want 00", {locked, seq_err}); else n_pass++;
    endtask

    task automatic test_spec_words;
        logic [15:0] w   [4] = '{16'h0000, 16'h0020, 16'h0001, 16'h0003};
        bit          ec  [4] = '{0, 1, 1, 0};
        bit          eu  [4] = '{0, 0, 0, 1};
        int          ecc [4] = '{0, 1, 2, 2};
        int          euc [4] = '{0, 0, 0, 1};
        for (int i = 0; i < 4; i++) begin
            step(1, w[i], 0, 1, mk(1, 0, ec[i], eu[i]));
            n_total++; if (valid_out !== 1'b0) $display("FAIL spec%0d_latency: valid_out got %b want 0 one edge in", i, valid_out); else n_pass++;
            idle(1);
            n_total++; if (valid_out !== 1'b1) $display("FAIL spec%0d_valid: got %b want 1", i, valid_out); else n_pass++;
            n_total++; if (data_out !== 11'd0) $display("FAIL spec%0d_data: got %0d want 0", i, data_out); else n_pass++;
            n_total++; if ({err_corr, err_uncorr} !== {ec[i], eu[i]}) $display("FAIL spec%0d_flags: got %b want %b", i, {err_corr, err_uncorr}, {ec[i], eu[i]}); else n_pass++;
            n_total++; if (corr_cnt !== 8'(ecc[i])) $display("FAIL spec%0d_corr_cnt: got %0d want %0d", i, corr_cnt, ecc[i]); else n_pass++;
            n_total++; if (uncorr_cnt !== 8'(euc[i])) $display("FAIL spec%0d_uncorr_cnt: got %0d want %0d", i, uncorr_cnt, euc[i]); else n_pass++;
            idle(1);
            n_total++; if ({valid_out, err_corr, err_uncorr} !== 3'b000) $display("FAIL spec%0d_idle: got %b want 000", i, {valid_out, err_corr, err_uncorr}); else n_pass++;
        end
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 300; i++) begin
            step(1, 16'h0003, 0, 1, mk(1, 0, 0, 1));
            if (cur.vld) begin
                n_total++; if (err_uncorr !== 1'b1) $display("FAIL sat_flag[%0d]: got %b want 1", i, err_uncorr); else n_pass++;
            end
        end
        idle(1);
        n_total++; if (uncorr_cnt !== 8'd255) $display("FAIL sat_uncorr_cnt: got %0d want 255", uncorr_cnt); else n_pass++;
        // clear on the very edge that presents an error word
        step(1, 16'h0003, 0, 1, mk(1, 0, 0, 1));
        step(0, 16'h0000, 1, 1, mk(0, 0, 0, 0));
        n_total++; if (err_uncorr !== 1'b1) $display("FAIL clr_word_flag: got %b want 1", err_uncorr); else n_pass++;
        n_total++; if (uncorr_cnt !== 8'd0) $display("FAIL clr_priority: got %0d want 0", uncorr_cnt); else n_pass++;
        n_total++; if (corr_cnt !== 8'd0) $display("FAIL clr_corr_cnt: got %0d want 0", corr_cnt); else n_pass++;
        step(1, 16'h0003, 0, 1, mk(1, 0, 0, 1));
        idle(1);
        n_total++; if (uncorr_cnt !== 8'd1) $display("FAIL clr_then_count: got %0d want 1", uncorr_cnt); else n_pass++;
    endtask

    task automatic test_exhaustive;
        logic [15:0] w;
        for (int d = 0; d < 2048; d++) begin
            for (int b = 0; b < 16; b++) begin
                w = encode(11'(d));
                w[b] = ~w[b];
                step(1, w, 0, 1, mk(1, 11'(d), 1, 0));
                if (cur.vld) begin
                    n_total++; if (data_out !== cur.data) $display("FAIL exh_data d=%0d b=%0d: got %0d want %0d", d, b, data_out, cur.data); else n_pass++;
                    n_total++; if ({err_corr, err_uncorr} !== 2'b10) $display("FAIL exh_flags d=%0d b=%0d: got %b want 10", d, b, {err_corr, err_uncorr}); else n_pass++;
                end
                n_total++; if ({locked, seq_err} !== {m_locked, m_seq_err}) $display("FAIL exh_seq d=%0d b=%0d: got %b want %b", d, b, {locked, seq_err}, {m_locked, m_seq_err}); else n_pass++;
            end
        end
        idle(1);
        n_total++; if (corr_cnt !== 8'(m_corr)) $display("FAIL exh_corr_cnt: got %0d want %0d", corr_cnt, m_corr); else n_pass++;
    endtask

    task automatic test_double;
        logic [15:0] w;
        logic [10:0] d;
        int b1, b2;
        for (int i = 0; i < 500; i++) begin
            d  = 11'($urandom_range(0, 2047));
            b1 = $urandom_range(0, 15);
            b2 = (b1 + $urandom_range(1, 15)) % 16;
            w  = encode(d);
            w[b1] = ~w[b1];
            w[b2] = ~w[b2];
            step(1, w, 0, 1, mk(1, raw_data(w), 0, 1));
            if (cur.vld) begin
                n_total++; if ({err_corr, err_uncorr} !== 2'b01) $display("FAIL dbl_flags[%0d]: got %b want 01", i, {err_corr, err_uncorr}); else n_pass++;
                n_total++; if (data_out !== cur.data) $display("FAIL dbl_raw_data[%0d]: got %0d want %0d", i, data_out, cur.data); else n_pass++;
            end
        end
        idle(1);
        n_total++; if (uncorr_cnt !== 8'(m_uncorr)) $display("FAIL dbl_uncorr_cnt: got %0d want %0d", uncorr_cnt, m_uncorr); else n_pass++;
    endtask

    // -1 idle cycle, -2 reset cycle, >=4096 double-flipped word carrying value-4096
    task automatic test_seq;
        int          seq[$] = '{-2, 0, 1, 2, 5, 6, 7, -1, -2, 2044, 2045, 2046, 2047, 0, 1,
                                -1, -1, -1, -1, -1, -1, 2, 4096 + 3, 4, 5, 9, -1, -1};
        logic [15:0] w;
        int          pulses;
        int          exp_pulses;
        pulses = 0;
        exp_pulses = 0;
        foreach (seq[i]) begin
            if (seq[i] == -2) begin
                step(0, 16'h0000, 0, 0, mk(0, 0, 0, 0));
            end else if (seq[i] == -1) begin
                idle(1);
            end else if (seq[i] >= 4096) begin
                w = encode(11'(seq[i] - 4096)) ^ 16'h0003;
                step(1, w, 0, 1, mk(1, raw_data(w), 0, 1));
            end else begin
                step(1, encode(11'(seq[i])), 0, 1, mk(1, 11'(seq[i]), 0, 0));
            end
            if (seq_err === 1'b1) pulses++;
            if (m_seq_err) exp_pulses++;
            n_total++; if (locked !== m_locked) $display("FAIL seq_locked[%0d]: got %b want %b", i, locked, m_locked); else n_pass++;
            n_total++; if (seq_err !== m_seq_err) $display("FAIL seq_err[%0d]: got %b want %b", i, seq_err, m_seq_err); else n_pass++;
        end
        n_total++; if (pulses !== exp_pulses) $display("FAIL seq_pulse_count: got %0d want %0d", pulses, exp_pulses); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [15:0] w;
        logic [10:0] nxt;
        item_t       e;
        bit          v, clr;
        int          kind, b1, b2;
        nxt = 11'd100;
        for (int i = 0; i < 600; i++) begin
            v    = ($urandom_range(0, 3) != 0);
            clr  = ($urandom_range(0, 29) == 0);
            kind = $urandom_range(0, 5);
            b1   = $urandom_range(0, 15);
            b2   = (b1 + $urandom_range(1, 15)) % 16;
            w    = encode(nxt);
            if (kind == 1 || kind == 2) begin
                w[b1] = ~w[b1];
                e = mk(v, nxt, 1, 0);
            end else if (kind == 3) begin
                w[b1] = ~w[b1];
                w[b2] = ~w[b2];
                e = mk(v, raw_data(w), 0, 1);
            end else begin
                e = mk(v, nxt, 0, 0);
            end
            step(v, w, clr, 1, e);
            if (v) nxt = ($urandom_range(0, 11) == 0) ? 11'($urandom_range(0, 2047)) : nxt + 11'd1;
            n_total++; if (valid_out !== cur.vld) $display("FAIL b2b_valid[%0d]: got %b want %b", i, valid_out, cur.vld); else n_pass++;
            if (cur.vld) begin
                n_total++; if (data_out !== cur.data) $display("FAIL b2b_data[%0d]: got %0d want %0d", i, data_out, cur.data); else n_pass++;
            end
            n_total++; if ({err_corr, err_uncorr} !== {cur.vld & cur.corr, cur.vld & cur.uncorr}) $display("FAIL b2b_flags[%0d]: got %b want %b", i, {err_corr, err_uncorr}, {cur.vld & cur.corr, cur.vld & cur.uncorr}); else n_pass++;
            n_total++; if ({corr_cnt, uncorr_cnt} !== {8'(m_corr), 8'(m_uncorr)}) $display("FAIL b2b_cnts[%0d]: got %0d/%0d want %0d/%0d", i, corr_cnt, uncorr_cnt, m_corr, m_uncorr); else n_pass++;
            n_total++; if ({locked, seq_err} !== {m_locked, m_seq_err}) $display("FAIL b2b_seq[%0d]: got %b want %b", i, {locked, seq_err}, {m_locked, m_seq_err}); else n_pass++;
        end
    endtask

    task automatic test_reset_inflight;
        step(1, 16'h0003, 0, 1, mk(1, 0, 0, 1));
        step(1, 16'h0020, 0, 0, mk(1, 0, 1, 0));
        for (int i = 0; i < 3; i++) begin
            idle(1);
            n_total++; if (valid_out !== 1'b0) $display("FAIL inflight_valid[%0d]: got %b want 0", i, valid_out); else n_pass++;
            n_total++; if ({corr_cnt, uncorr_cnt} !== 16'h0000) $display("FAIL inflight_cnts[%0d]: got %h want 0000", i, {corr_cnt, uncorr_cnt}); else n_pass++;
            n_total++; if (locked !== 1'b0) $display("FAIL inflight_locked[%0d]: got %b want 0", i, locked); else n_pass++;
        end
        step(1, encode(11'd77), 0, 1, mk(1, 11'd77, 0, 0));
        n_total++; if (valid_out !== 1'b0) $display("FAIL post_reset_early: got %b want 0", valid_out); else n_pass++;
        idle(1);
        n_total++; if ({valid_out, data_out} !== {1'b1, 11'd77}) $display("FAIL post_reset_word: got %b/%0d want 1/77", valid_out, data_out); else n_pass++;
    endtask

    initial begin
        rst = 1'b0;
        valid_in = 1'b0;
        code_in = '0;
        clr_cnt = 1'b0;
        test_reset;
        test_spec_words;
        test_saturation;
        test_exhaustive;
        test_double;
        test_seq;
        test_back_to_back;
        test_reset_inflight;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
